// File: rtl/param_cpu_core_pkg.sv
// Shared definitions for param_cpu_core: opcode and FSM state encodings plus
// small opcode-classification helpers used by the core decode.
package param_cpu_core_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_LDI  = 4'h6,
        OP_MOV  = 4'h7,
        OP_INC  = 4'h8,
        OP_BEQZ = 4'h9,
        OP_JMP  = 4'hA,
        OP_HALT = 4'hF
    } op_e;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_EXEC   = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    // Opcodes 0xB..0xE are reserved and must flag an error.
    function automatic logic op_is_legal(input op_e op);
        return !(op inside {[4'hB:4'hE]});
    endfunction

    function automatic logic op_uses_rd(input op_e op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                          OP_LDI, OP_MOV, OP_INC, OP_BEQZ};
    endfunction

    function automatic logic op_uses_rs(input op_e op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV};
    endfunction

    function automatic logic op_writes_rd(input op_e op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                          OP_LDI, OP_MOV, OP_INC};
    endfunction

    function automatic logic op_sets_flags(input op_e op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_INC};
    endfunction

endpackage

// File: rtl/param_cpu_core_if.sv
// Instruction-fetch handshake between the core (master) and instruction memory (slave).
interface param_cpu_core_if #(
    parameter int PC_W    = 8,
    parameter int FIELD_W = 8
);
    localparam int INSTR_W = 4 + 2 * FIELD_W;

    logic               instr_req;
    logic [PC_W-1:0]    instr_addr;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr_data;

    modport master (
        output instr_req,
        output instr_addr,
        input  instr_valid,
        input  instr_data
    );

    modport slave (
        input  instr_req,
        input  instr_addr,
        output instr_valid,
        output instr_data
    );

endinterface

// File: rtl/param_cpu_core_alu.sv
// Combinational two's-complement ALU: wrapping arithmetic with signed-overflow
// and zero detection; logic ops always report no overflow.
module param_cpu_core_alu
    import param_cpu_core_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  op_e               op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o,
    output logic              z_o,
    output logic              v_o
);

    localparam int MSB = DATA_W - 1;

    // NOTE: every output gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        result_o = a_i;
        v_o      = 1'b0;
        case (op_i)
            OP_ADD: begin
                result_o = a_i + b_i;
                v_o      = (a_i[MSB] == b_i[MSB]) && (result_o[MSB] != a_i[MSB]);
            end
            OP_SUB: begin
                result_o = a_i - b_i;
                v_o      = (a_i[MSB] != b_i[MSB]) && (result_o[MSB] != a_i[MSB]);
            end
            OP_INC: begin
                result_o = a_i + DATA_W'(1);
                v_o      = !a_i[MSB] && result_o[MSB];
            end
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            default: result_o = a_i;
        endcase
    end

    assign z_o = (result_o == '0);

endmodule

// File: rtl/param_cpu_core.sv
// Multi-cycle accumulator-style core: FETCH/EXEC/HALTED FSM, instruction
// register, PC, register file and Z/V flags, with hold stall and sticky error.
module param_cpu_core
    import param_cpu_core_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4,
    parameter int FIELD_W  = 8,
    parameter int PC_W     = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       hold,
    param_cpu_core_if.master           fetch,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic [PC_W-1:0]            pc,
    output logic                       flag_z,
    output logic                       flag_v,
    output logic                       halted,
    output logic                       err
);

    localparam int INSTR_W = 4 + 2 * FIELD_W;
    localparam int IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    // One extra bit so a NUM_REGS of exactly 2**FIELD_W still compares correctly.
    localparam logic [FIELD_W:0] REG_LIMIT = (FIELD_W + 1)'(NUM_REGS);

    state_e             state_q;
    logic [INSTR_W-1:0] ir_q;
    logic [PC_W-1:0]    pc_q;
    logic [DATA_W-1:0]  regs_q [NUM_REGS];
    logic               z_q, v_q, halted_q, err_q;

    op_e               op;
    logic [FIELD_W-1:0] fa, fb;
    logic [IDX_W-1:0]  rd_idx, rs_idx;
    logic              rd_ok, rs_ok, bad;
    logic [DATA_W-1:0] rd_val, rs_val, alu_res, wr_data_d;
    logic              alu_z, alu_v, wr_en_d;
    logic [PC_W-1:0]   pc_inc, pc_d;

    assign op     = op_e'(ir_q[INSTR_W-1 -: 4]);
    assign fa     = ir_q[2*FIELD_W-1 -: FIELD_W];
    assign fb     = ir_q[FIELD_W-1:0];
    assign rd_idx = IDX_W'(fa);
    assign rs_idx = IDX_W'(fb);
    assign rd_ok  = {1'b0, fa} < REG_LIMIT;
    assign rs_ok  = {1'b0, fb} < REG_LIMIT;
    assign rd_val = regs_q[rd_idx];
    assign rs_val = regs_q[rs_idx];

    // Any illegal opcode or out-of-range register index degrades to a NOP.
    assign bad = !op_is_legal(op)
              || (op_uses_rd(op) && !rd_ok)
              || (op_uses_rs(op) && !rs_ok);

    param_cpu_core_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i     (op),
        .a_i      (rd_val),
        .b_i      (rs_val),
        .result_o (alu_res),
        .z_o      (alu_z),
        .v_o      (alu_v)
    );

    assign pc_inc = pc_q + PC_W'(1);

    always_comb begin
        pc_d      = pc_inc;
        wr_en_d   = !bad && op_writes_rd(op);
        wr_data_d = alu_res;
        if (!bad) begin
            case (op)
                OP_JMP:  pc_d = PC_W'(fb);
                OP_BEQZ: pc_d = (rd_val == '0) ? PC_W'(fb) : pc_inc;
                OP_HALT: pc_d = pc_q;
                default: pc_d = pc_inc;
            endcase
        end
        if (op == OP_LDI) wr_data_d = DATA_W'(fb);
        if (op == OP_MOV) wr_data_d = rs_val;
    end

    // NOTE: the register file is reset along with the rest of the state because
    // the display logic reads it directly and must see zeros after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_FETCH;
            ir_q     <= '0;
            pc_q     <= '0;
            z_q      <= 1'b0;
            v_q      <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (!hold) begin
            // NOTE: non-blocking assignments so every update in EXEC commits
            // together on the same edge, independent of statement order.
            case (state_q)
                ST_FETCH: begin
                    if (fetch.instr_valid) begin
                        ir_q    <= fetch.instr_data;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    pc_q <= pc_d;
                    if (wr_en_d) regs_q[rd_idx] <= wr_data_d;
                    if (!bad && op_sets_flags(op)) begin
                        z_q <= alu_z;
                        v_q <= alu_v;
                    end
                    if (bad) err_q <= 1'b1;
                    if (!bad && op == OP_HALT) begin
                        halted_q <= 1'b1;
                        state_q  <= ST_HALTED;
                    end else begin
                        state_q  <= ST_FETCH;
                    end
                end
                ST_HALTED: state_q <= ST_HALTED;
                default:   state_q <= ST_FETCH;
            endcase
        end
    end

    // Request is gated by reset so it reads low while reset is asserted.
    assign fetch.instr_req  = reset && !hold && (state_q == ST_FETCH);
    assign fetch.instr_addr = pc_q;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_flat
        assign regs_flat[r*DATA_W +: DATA_W] = regs_q[r];
    end

    assign pc     = pc_q;
    assign flag_z = z_q;
    assign flag_v = v_q;
    assign halted = halted_q;
    assign err    = err_q;

endmodule

// File: tb/tb_param_cpu_core.sv
// Directed bench for param_cpu_core: small programs in a bench-side ROM with
// hand-computed final register, flag and PC values.
module tb_param_cpu_core;
    import param_cpu_core_pkg::*;

    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 4;
    localparam int FIELD_W  = 8;
    localparam int PC_W     = 8;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        hold  = 1'b0;
    logic [31:0] regs_flat;
    logic [7:0]  pc;
    logic        flag_z, flag_v, halted, err;

    logic [19:0] rom [256];
    int          mem_wait  = 0;
    int          wait_cnt  = 0;
    int          fetch_cnt = 0;
    int          errors    = 0;
    int          checks    = 0;

    param_cpu_core_if #(.PC_W(PC_W), .FIELD_W(FIELD_W)) fetch ();

    param_cpu_core #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .FIELD_W(FIELD_W), .PC_W(PC_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .hold      (hold),
        .fetch     (fetch),
        .regs_flat (regs_flat),
        .pc        (pc),
        .flag_z    (flag_z),
        .flag_v    (flag_v),
        .halted    (halted),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Memory model: data always presented; valid after mem_wait cycles since the last accept.
    assign fetch.instr_data  = rom[fetch.instr_addr];
    assign fetch.instr_valid = (wait_cnt >= mem_wait);

    always @(posedge clk) begin
        if (fetch.instr_req && fetch.instr_valid) begin
            wait_cnt  <= 0;
            fetch_cnt <= fetch_cnt + 1;
        end else if (wait_cnt < 100) begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [19:0] enc(input logic [3:0] op, input logic [7:0] fa,
                                        input logic [7:0] fb);
        return {op, fa, fb};
    endfunction

    function automatic logic [7:0] rg(input int i);
        return regs_flat[i*8 +: 8];
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = enc(4'hF, 8'd0, 8'd0);
    endtask

    task automatic load_add_prog();
        clear_rom();
        rom[0] = enc(4'h6, 8'd0, 8'd5);
        rom[1] = enc(4'h6, 8'd1, 8'd3);
        rom[2] = enc(4'h1, 8'd0, 8'd1);
        rom[3] = enc(4'hF, 8'd0, 8'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_to_halt(input int max_cyc, output int cyc);
        cyc = 0;
        while (!halted && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_timeout: halted=%b after %0d cycles, want 1", halted, cyc);
        end
    endtask

    task automatic test_reset();
        load_add_prog();
        @(negedge clk);
        #1;
        checks++; if (regs_flat !== 32'h0) begin errors++; $display("FAIL rst_regs: got %h want 0", regs_flat); end
        checks++; if (pc !== 8'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", pc); end
        checks++; if ({flag_z, flag_v, halted, err} !== 4'b0) begin errors++; $display("FAIL rst_flags: got %b want 0000", {flag_z, flag_v, halted, err}); end
        checks++; if (fetch.instr_req !== 1'b0) begin errors++; $display("FAIL rst_req_low: got %b want 0", fetch.instr_req); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (fetch.instr_req !== 1'b1) begin errors++; $display("FAIL rst_first_req: got %b want 1", fetch.instr_req); end
        // Five edges: LDI, LDI executed and ADD captured, now mid-EXEC.
        @(negedge clk);
        repeat (4) @(negedge clk);
        checks++; if (regs_flat !== 32'h0000_0305) begin errors++; $display("FAIL pre_abort_regs: got %h want 00000305", regs_flat); end
        #1;
        reset = 1'b0;
        #1;
        checks++; if (regs_flat !== 32'h0) begin errors++; $display("FAIL abort_regs: got %h want 0", regs_flat); end
        checks++; if (pc !== 8'h0) begin errors++; $display("FAIL abort_pc: got %h want 0", pc); end
        checks++; if ({halted, err} !== 2'b0) begin errors++; $display("FAIL abort_halt_err: got %b want 00", {halted, err}); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        // ADD was aborted, so the first edge after release fetched address 0 again.
        checks++; if (regs_flat !== 32'h0) begin errors++; $display("FAIL abort_no_commit: got %h want 0", regs_flat); end
    endtask

    task automatic test_add_program();
        int cyc, base;
        load_add_prog();
        mem_wait = 0;
        apply_reset();
        base = fetch_cnt;
        run_to_halt(50, cyc);
        checks++; if (cyc != 8) begin errors++; $display("FAIL add_cycles: got %0d want 8", cyc); end
        checks++; if (regs_flat !== 32'h0000_0308) begin errors++; $display("FAIL add_regs: got %h want 00000308", regs_flat); end
        checks++; if ({flag_z, flag_v} !== 2'b00) begin errors++; $display("FAIL add_flags: got %b want 00", {flag_z, flag_v}); end
        checks++; if (pc !== 8'd3) begin errors++; $display("FAIL add_pc: got %0d want 3", pc); end
        @(negedge clk);
        checks++; if (fetch.instr_req !== 1'b0) begin errors++; $display("FAIL add_req_after_halt: got %b want 0", fetch.instr_req); end
        checks++; if (fetch_cnt - base != 4) begin errors++; $display("FAIL add_fetches: got %0d want 4", fetch_cnt - base); end
    endtask

    task automatic test_overflow();
        int cyc;
        clear_rom();
        rom[0] = enc(4'h6, 8'd0, 8'h7F);
        rom[1] = enc(4'h8, 8'd0, 8'd0);
        rom[2] = enc(4'h2, 8'd0, 8'd0);
        apply_reset();
        repeat (4) @(negedge clk);
        checks++; if (rg(0) !== 8'h80) begin errors++; $display("FAIL inc_result: got %h want 80", rg(0)); end
        checks++; if ({flag_z, flag_v} !== 2'b01) begin errors++; $display("FAIL inc_flags: got z/v=%b want 01", {flag_z, flag_v}); end
        run_to_halt(50, cyc);
        checks++; if (rg(0) !== 8'h00) begin errors++; $display("FAIL sub_result: got %h want 00", rg(0)); end
        checks++; if ({flag_z, flag_v} !== 2'b10) begin errors++; $display("FAIL sub_flags: got z/v=%b want 10", {flag_z, flag_v}); end
        checks++; if (pc !== 8'd3) begin errors++; $display("FAIL ovf_pc: got %0d want 3", pc); end
    endtask

    task automatic test_loop();
        int cyc, base;
        clear_rom();
        rom[0] = enc(4'h6, 8'd2, 8'd3);
        rom[1] = enc(4'h6, 8'd3, 8'd1);
        rom[2] = enc(4'h2, 8'd2, 8'd3);
        rom[3] = enc(4'h9, 8'd2, 8'd5);
        rom[4] = enc(4'hA, 8'd0, 8'd2);
        rom[5] = enc(4'hF, 8'd0, 8'd0);
        apply_reset();
        base = fetch_cnt;
        run_to_halt(100, cyc);
        checks++; if (rg(2) !== 8'd0 || rg(3) !== 8'd1) begin errors++; $display("FAIL loop_regs: got r2=%h r3=%h want 00 01", rg(2), rg(3)); end
        checks++; if (pc !== 8'd5) begin errors++; $display("FAIL loop_pc: got %0d want 5", pc); end
        // Ten loop instructions plus the HALT itself.
        checks++; if (fetch_cnt - base != 11) begin errors++; $display("FAIL loop_fetches: got %0d want 11", fetch_cnt - base); end
        checks++; if (cyc != 22) begin errors++; $display("FAIL loop_cycles: got %0d want 22", cyc); end
    endtask

    task automatic test_pc_wrap();
        int cyc, base;
        clear_rom();
        rom[0]   = enc(4'h9, 8'd1, 8'd3);
        rom[1]   = enc(4'hF, 8'd0, 8'd0);
        rom[3]   = enc(4'h8, 8'd1, 8'd0);
        rom[4]   = enc(4'hA, 8'd0, 8'hFF);
        rom[255] = enc(4'h0, 8'd0, 8'd0);
        apply_reset();
        base = fetch_cnt;
        run_to_halt(60, cyc);
        checks++; if (pc !== 8'd1) begin errors++; $display("FAIL wrap_pc: got %0d want 1", pc); end
        checks++; if (rg(1) !== 8'd1) begin errors++; $display("FAIL wrap_r1: got %h want 01", rg(1)); end
        checks++; if (fetch_cnt - base != 6) begin errors++; $display("FAIL wrap_fetches: got %0d want 6", fetch_cnt - base); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL wrap_err: got %b want 0", err); end
    endtask

    task automatic test_stalls();
        int cyc, base, n;
        load_add_prog();
        mem_wait = 3;
        apply_reset();
        base = fetch_cnt;
        n = 0;
        while (fetch_cnt - base < 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++; if (fetch_cnt - base != 3) begin errors++; $display("FAIL stall_reach_add: got %0d fetches want 3", fetch_cnt - base); end
        hold = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++; if (fetch.instr_req !== 1'b0 || rg(0) !== 8'd5) begin errors++; $display("FAIL hold_exec_%0d: got req=%b r0=%h want 0 05", k, fetch.instr_req, rg(0)); end
        end
        hold = 1'b0;
        @(negedge clk);
        checks++; if (rg(0) !== 8'd8) begin errors++; $display("FAIL stall_add_commit: got %h want 08", rg(0)); end
        n = 0;
        while (fetch.instr_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        // hold and valid together: no capture, so HALT needs two more edges afterwards.
        hold = 1'b1;
        @(negedge clk);
        checks++; if (fetch.instr_req !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL hold_fetch: got req=%b halted=%b want 0 0", fetch.instr_req, halted); end
        hold = 1'b0;
        @(negedge clk);
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL hold_wins: got halted=%b want 0", halted); end
        run_to_halt(50, cyc);
        checks++; if (regs_flat !== 32'h0000_0308) begin errors++; $display("FAIL stall_regs: got %h want 00000308", regs_flat); end
        checks++; if (pc !== 8'd3 || flag_z !== 1'b0) begin errors++; $display("FAIL stall_pc_z: got pc=%0d z=%b want 3 0", pc, flag_z); end
        checks++; if (fetch_cnt - base != 4) begin errors++; $display("FAIL stall_fetches: got %0d want 4", fetch_cnt - base); end
        mem_wait = 0;
    endtask

    task automatic test_error();
        int cyc;
        clear_rom();
        rom[0] = enc(4'h6, 8'd0, 8'd9);
        rom[1] = enc(4'h1, 8'd7, 8'd0);
        rom[2] = enc(4'hC, 8'd0, 8'd0);
        apply_reset();
        repeat (4) @(negedge clk);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_bad_index: got %b want 1", err); end
        checks++; if (pc !== 8'd2 || regs_flat !== 32'h0000_0009) begin errors++; $display("FAIL err_index_nop: got pc=%0d regs=%h want 2 00000009", pc, regs_flat); end
        run_to_halt(50, cyc);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err); end
        checks++; if (pc !== 8'd3 || regs_flat !== 32'h0000_0009) begin errors++; $display("FAIL err_illegal_op: got pc=%0d regs=%h want 3 00000009", pc, regs_flat); end
        apply_reset();
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b want 0", err); end
    endtask

    initial begin
        test_reset();
        test_add_program();
        test_overflow();
        test_loop();
        test_pc_wrap();
        test_stalls();
        test_error();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
